// File: rtl/trace_buffer_mc.sv
// Multi-channel trigger-windowed trace capture buffer: records {timestamp, payload}
// of one selected channel into a circular RAM around a trigger, then drains oldest-first.
module trace_buffer_mc #(
    parameter  int Fpay     = 32,
    parameter  int CH       = 4,
    parameter  int TB_Depth = 512,
    parameter  int TS_W     = 16,
    localparam int AW       = $clog2(TB_Depth),
    localparam int CW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CH*Fpay-1:0]   trace_in,
    input  logic [CH-1:0]        trace_valid,
    input  logic [CW-1:0]        ch_sel,
    input  logic                 arm,
    input  logic                 trigger_in,
    input  logic [AW:0]          post_count,
    input  logic                 rd_en,
    output logic [TS_W+Fpay-1:0] dout,
    output logic                 dout_valid,
    output logic                 rd_empty,
    output logic [1:0]           state,
    output logic                 wrapped,
    output logic [AW:0]          count,
    output logic [TS_W-1:0]      trig_ts
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW:0] DEPTH   = (AW+1)'(TB_Depth);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic [TS_W+Fpay-1:0] mem [TB_Depth];

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        sel_q, sel_d;
    logic [AW:0]          post_len_q, post_len_d;
    logic [AW:0]          post_cnt_q, post_cnt_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [AW:0]          unread_q, unread_d;
    logic                 wrapped_q, wrapped_d;
    logic [TS_W-1:0]      trig_ts_q, trig_ts_d;
    logic [TS_W-1:0]      ts_q;
    logic [TS_W+Fpay-1:0] dout_q;
    logic                 dout_valid_q, dout_valid_d;
    logic                 rd_accept;
    logic                 wr_en;
    logic [Fpay-1:0]      sel_payload;

    assign sel_payload = trace_in[sel_q*Fpay +: Fpay];
    // arm takes priority over everything, including the sample in its own cycle.
    assign wr_en = ((state_q == S_ARMED) || (state_q == S_POST)) && !arm && trace_valid[sel_q];

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d      = state_q;
        sel_d        = sel_q;
        post_len_d   = post_len_q;
        post_cnt_d   = post_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        unread_d     = unread_q;
        wrapped_d    = wrapped_q;
        trig_ts_d    = trig_ts_q;
        dout_valid_d = 1'b0;
        rd_accept    = 1'b0;

        if (arm) begin
            state_d    = S_ARMED;
            sel_d      = ch_sel;
            post_len_d = (post_count > DEPTH) ? DEPTH : post_count;
            post_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            unread_d   = '0;
            wrapped_d  = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (count_q == DEPTH) wrapped_d = 1'b1;
                else                  count_d   = count_q + CNT_ONE;
            end

            case (state_q)
                S_ARMED: begin
                    if (trigger_in) begin
                        trig_ts_d = ts_q;
                        if (post_len_q == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_POST;
                            post_cnt_d = post_len_q;
                        end
                    end
                end
                S_POST: begin
                    if (wr_en) begin
                        post_cnt_d = post_cnt_q - CNT_ONE;
                        if (post_cnt_q == CNT_ONE) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (rd_en && (unread_q != '0)) begin
                        rd_accept    = 1'b1;
                        rd_ptr_d     = rd_ptr_q + 1'b1;
                        unread_d     = unread_q - CNT_ONE;
                        dout_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase

            // Readout starts at the oldest surviving entry, using post-write pointer state.
            if ((state_q != S_DONE) && (state_d == S_DONE)) begin
                rd_ptr_d = wrapped_d ? wr_ptr_d : '0;
                unread_d = count_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            post_len_q   <= '0;
            post_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            unread_q     <= '0;
            wrapped_q    <= 1'b0;
            trig_ts_q    <= '0;
            ts_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            sel_q        <= sel_d;
            post_len_q   <= post_len_d;
            post_cnt_q   <= post_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            unread_q     <= unread_d;
            wrapped_q    <= wrapped_d;
            trig_ts_q    <= trig_ts_d;
            ts_q         <= ts_q + 1'b1;
            dout_valid_q <= dout_valid_d;
            if (rd_accept) dout_q <= mem[rd_ptr_q];
        end
    end

    // NOTE: the storage array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= {ts_q, sel_payload};
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign rd_empty   = (state_q != S_DONE) || (unread_q == '0);
    assign state      = state_q;
    assign wrapped    = wrapped_q;
    assign count      = count_q;
    assign trig_ts    = trig_ts_q;

endmodule
